// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline skid stage: EX/MEM payload layout, NOP bubble
// value and small elaboration-time helpers.
package pipe_skid_stage_pkg;

    localparam int WD_W       = 5;
    localparam int WREG_W     = 1;
    localparam int WDATA_W    = 32;
    localparam int MEM_ADDR_W = 32;
    localparam int ALUOP_W    = 8;

    localparam int EX_MEM_PAYLOAD_W = WD_W + WREG_W + WDATA_W + MEM_ADDR_W + ALUOP_W;

    // Field offsets inside the packed payload, LSB first.
    localparam int ALUOP_LSB    = 0;
    localparam int MEM_ADDR_LSB = ALUOP_LSB + ALUOP_W;
    localparam int WDATA_LSB    = MEM_ADDR_LSB + MEM_ADDR_W;
    localparam int WREG_LSB     = WDATA_LSB + WDATA_W;
    localparam int WD_LSB       = WREG_LSB + WREG_W;

    localparam logic [WD_W-1:0]    NOP_REG_ADDR  = '0;
    localparam logic               WRITE_DISABLE = 1'b0;
    localparam logic [WDATA_W-1:0] ZERO_WORD     = '0;
    localparam logic [ALUOP_W-1:0] ME_NOP_OP     = '0;

    typedef struct packed {
        logic [WD_W-1:0]       wd;
        logic                  wreg;
        logic [WDATA_W-1:0]    wdata;
        logic [MEM_ADDR_W-1:0] mem_addr;
        logic [ALUOP_W-1:0]    aluop;
    } ex_mem_payload_t;

    localparam logic [EX_MEM_PAYLOAD_W-1:0] EX_MEM_NOP_PAYLOAD =
        {NOP_REG_ADDR, WRITE_DISABLE, ZERO_WORD, ZERO_WORD, ME_NOP_OP};

    function automatic logic [EX_MEM_PAYLOAD_W-1:0] pack_ex_mem(input ex_mem_payload_t f);
        return f;
    endfunction

    function automatic ex_mem_payload_t unpack_ex_mem(input logic [EX_MEM_PAYLOAD_W-1:0] p);
        return ex_mem_payload_t'(p);
    endfunction

    // A single-entry queue still needs a one-bit pointer to keep port widths legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_wrap_ctr.sv
// Modulo-MODULUS pointer with increment and synchronous clear; wraps explicitly so
// non-power-of-two depths work.
module pipe_skid_stage_wrap_ctr #(
    parameter int MODULUS = 2,
    parameter int W       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    localparam logic [W-1:0] LAST = W'(MODULUS - 1);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline-boundary buffer: DEPTH-entry skid queue, synchronous flush,
// and a NOP bubble on the output whenever the queue is empty.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter  int                DATA_W      = EX_MEM_PAYLOAD_W,
    parameter  int                DEPTH       = 2,
    parameter  logic [DATA_W-1:0] NOP_PAYLOAD = {DATA_W{1'b0}},
    localparam int                CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_payload,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_payload,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int               PTR_W    = ptr_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              has_room;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              rd_adv;

    assign push   = up_valid & up_ready;
    assign pop    = dn_valid & dn_ready;
    // A flush drops the same-cycle push but the popped head has already left.
    assign wr_en  = push & ~flush;
    assign rd_adv = pop & ~flush;

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            has_room <= 1'b1;
        end else begin
            count    <= count_next;
            has_room <= (count_next < FULL_CNT);
        end
    end

    generate
        if (DEPTH == 1) begin : g_passthru
            // Single entry: a departing head frees the slot in the same cycle.
            assign up_ready = has_room | dn_ready;
        end else begin : g_skid
            assign up_ready = has_room;
        end
    endgenerate

    pipe_skid_stage_wrap_ctr #(
        .MODULUS (DEPTH),
        .W       (PTR_W)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_en),
        .clr (flush),
        .ptr (wr_ptr)
    );

    pipe_skid_stage_wrap_ctr #(
        .MODULUS (DEPTH),
        .W       (PTR_W)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_adv),
        .clr (flush),
        .ptr (rd_ptr)
    );

    // NOTE: storage has no reset; count gates every read, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= up_payload;
        end
    end

    assign dn_valid   = (count != '0);
    assign dn_payload = dn_valid ? mem[rd_ptr] : NOP_PAYLOAD;
    assign occupancy  = count;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three instances (DEPTH 1, 2, 3) checked against a
// list-based reference model plus directed scenarios.
module tb_pipe_skid_stage;

    localparam int             DW  = 8;
    localparam logic [DW-1:0]  NOP = 8'hA5;
    localparam int             DEP [3] = '{1, 2, 3};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          flush      [3];
    logic          up_valid   [3];
    logic          up_ready   [3];
    logic [DW-1:0] up_payload [3];
    logic          dn_valid   [3];
    logic          dn_ready   [3];
    logic [DW-1:0] dn_payload [3];
    logic [0:0]    occ1;
    logic [1:0]    occ2;
    logic [1:0]    occ3;
    int            occ [3];

    always_comb begin
        occ[0] = int'(occ1);
        occ[1] = int'(occ2);
        occ[2] = int'(occ3);
    end

    pipe_skid_stage #(.DATA_W(DW), .DEPTH(1), .NOP_PAYLOAD(NOP)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush[0]),
        .up_valid(up_valid[0]), .up_ready(up_ready[0]), .up_payload(up_payload[0]),
        .dn_valid(dn_valid[0]), .dn_ready(dn_ready[0]), .dn_payload(dn_payload[0]),
        .occupancy(occ1)
    );

    pipe_skid_stage #(.DATA_W(DW), .DEPTH(2), .NOP_PAYLOAD(NOP)) u_d2 (
        .clk(clk), .rst(rst), .flush(flush[1]),
        .up_valid(up_valid[1]), .up_ready(up_ready[1]), .up_payload(up_payload[1]),
        .dn_valid(dn_valid[1]), .dn_ready(dn_ready[1]), .dn_payload(dn_payload[1]),
        .occupancy(occ2)
    );

    pipe_skid_stage #(.DATA_W(DW), .DEPTH(3), .NOP_PAYLOAD(NOP)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush[2]),
        .up_valid(up_valid[2]), .up_ready(up_ready[2]), .up_payload(up_payload[2]),
        .dn_valid(dn_valid[2]), .dn_ready(dn_ready[2]), .dn_payload(dn_payload[2]),
        .occupancy(occ3)
    );

    // Reference model: each stage is an ordered list, head at index 0.
    int            mn [3];
    logic [DW-1:0] mq [3][4];
    int            tests = 0;
    int            fails = 0;

    function automatic logic m_ready(input int k);
        if (DEP[k] == 1) return (mn[k] == 0) || dn_ready[k];
        return mn[k] < DEP[k];
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            flush[k]      = 1'b0;
            up_valid[k]   = 1'b0;
            up_payload[k] = '0;
            dn_ready[k]   = 1'b0;
        end
    endtask

    task automatic drive(input int i, input logic uv, input logic [DW-1:0] up,
                         input logic dr, input logic fl);
        @(negedge clk);
        idle_all();
        up_valid[i]   = uv;
        up_payload[i] = up;
        dn_ready[i]   = dr;
        flush[i]      = fl;
        #1;
    endtask

    task automatic advance();
        logic push [3];
        logic pop  [3];
        for (int k = 0; k < 3; k++) begin
            push[k] = up_valid[k] && m_ready(k);
            pop[k]  = (mn[k] != 0) && dn_ready[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (flush[k]) begin
                mn[k] = 0;
            end else begin
                if (pop[k]) begin
                    for (int j = 0; j < 3; j++) mq[k][j] = mq[k][j+1];
                    mn[k]--;
                end
                if (push[k]) begin
                    mq[k][mn[k]] = up_payload[k];
                    mn[k]++;
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) mn[k] = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++; if (dn_valid[k] !== 1'b0) begin fails++; $display("FAIL reset_dn_valid[%0d]: got %b want 0", k, dn_valid[k]); end
            tests++; if (dn_payload[k] !== NOP) begin fails++; $display("FAIL reset_payload[%0d]: got %h want %h", k, dn_payload[k], NOP); end
            tests++; if (occ[k] !== 0) begin fails++; $display("FAIL reset_occ[%0d]: got %0d want 0", k, occ[k]); end
            tests++; if (up_ready[k] !== 1'b1) begin fails++; $display("FAIL reset_up_ready[%0d]: got %b want 1", k, up_ready[k]); end
        end
    endtask

    task automatic test_fill_hold();
        drive(1, 1'b1, 8'h11, 1'b0, 1'b0);
        tests++; if (dn_valid[1] !== 1'b0) begin fails++; $display("FAIL fill_no_bypass: dn_valid got %b want 0", dn_valid[1]); end
        advance();
        drive(1, 1'b1, 8'h22, 1'b0, 1'b0);
        tests++; if (occ[1] !== 1) begin fails++; $display("FAIL fill_occ1: got %0d want 1", occ[1]); end
        tests++; if (dn_payload[1] !== 8'h11) begin fails++; $display("FAIL fill_head_a: got %h want 11", dn_payload[1]); end
        advance();
        for (int c = 0; c < 2; c++) begin
            drive(1, 1'b1, 8'h99, 1'b0, 1'b0);
            tests++; if (occ[1] !== 2) begin fails++; $display("FAIL fill_occ2: got %0d want 2", occ[1]); end
            tests++; if (up_ready[1] !== 1'b0) begin fails++; $display("FAIL fill_full_ready: got %b want 0", up_ready[1]); end
            tests++; if (dn_payload[1] !== 8'h11) begin fails++; $display("FAIL fill_hold: got %h want 11", dn_payload[1]); end
            advance();
        end
        drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (dn_payload[1] !== 8'h11) begin fails++; $display("FAIL drain_a: got %h want 11", dn_payload[1]); end
        advance();
        drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (dn_payload[1] !== 8'h22) begin fails++; $display("FAIL drain_b: got %h want 22", dn_payload[1]); end
        tests++; if (occ[1] !== 1) begin fails++; $display("FAIL drain_occ: got %0d want 1", occ[1]); end
        advance();
        drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests++; if (dn_valid[1] !== 1'b0) begin fails++; $display("FAIL drain_empty_valid: got %b want 0", dn_valid[1]); end
        tests++; if (dn_payload[1] !== NOP) begin fails++; $display("FAIL drain_empty_nop: got %h want %h", dn_payload[1], NOP); end
        advance();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            drive(1, c < 8, DW'(c + 1), 1'b1, 1'b0);
            if (c < 8) begin
                tests++; if (up_ready[1] !== 1'b1) begin fails++; $display("FAIL b2b_ready c=%0d: got %b want 1", c, up_ready[1]); end
            end
            if (c >= 1 && c <= 8) begin
                tests++; if (dn_payload[1] !== DW'(c)) begin fails++; $display("FAIL b2b_data c=%0d: got %h want %h", c, dn_payload[1], DW'(c)); end
                tests++; if (occ[1] !== 1) begin fails++; $display("FAIL b2b_occ c=%0d: got %0d want 1", c, occ[1]); end
            end
            if (c == 9) begin
                tests++; if (dn_valid[1] !== 1'b0) begin fails++; $display("FAIL b2b_end_valid: got %b want 0", dn_valid[1]); end
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        int   pushed = 0;
        int   popped = 0;
        int   cyc = 0;
        logic uv;
        logic dr;
        while ((pushed < 10 || mn[2] != 0) && cyc < 200) begin
            uv = (pushed < 10) && ($urandom_range(0, 3) != 0);
            dr = (pushed >= 10) || ($urandom_range(0, 1) == 1);
            drive(2, uv, 8'h60 + DW'(pushed), dr, 1'b0);
            if (dn_valid[2] && dr) begin
                tests++; if (dn_payload[2] !== 8'h60 + DW'(popped)) begin fails++; $display("FAIL wrap_order #%0d: got %h want %h", popped, dn_payload[2], 8'h60 + DW'(popped)); end
                popped++;
            end
            tests++; if (occ[2] > 3 || occ[2] !== mn[2]) begin fails++; $display("FAIL wrap_occ: got %0d want %0d", occ[2], mn[2]); end
            if (uv && m_ready(2)) pushed++;
            advance();
            cyc++;
        end
        tests++; if (popped !== 10) begin fails++; $display("FAIL wrap_drain: got %0d popped want 10 (cycles %0d)", popped, cyc); end
    endtask

    task automatic test_flush();
        drive(1, 1'b1, 8'h31, 1'b0, 1'b0); advance();
        drive(1, 1'b1, 8'h32, 1'b0, 1'b0); advance();
        drive(1, 1'b1, 8'h33, 1'b0, 1'b1);
        tests++; if (occ[1] !== 2) begin fails++; $display("FAIL flush_pre_occ: got %0d want 2", occ[1]); end
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1'b0, 8'h00, 1'b1, 1'b0);
            tests++; if (occ[1] !== 0) begin fails++; $display("FAIL flush_occ c=%0d: got %0d want 0", c, occ[1]); end
            tests++; if (dn_valid[1] !== 1'b0) begin fails++; $display("FAIL flush_valid c=%0d: got %b (payload %h) want 0", c, dn_valid[1], dn_payload[1]); end
            advance();
        end
    endtask

    task automatic test_depth1_replace();
        drive(0, 1'b1, 8'h44, 1'b0, 1'b0); advance();
        drive(0, 1'b1, 8'h55, 1'b1, 1'b0);
        tests++; if (up_ready[0] !== 1'b1) begin fails++; $display("FAIL d1_passthru_ready: got %b want 1", up_ready[0]); end
        tests++; if (dn_payload[0] !== 8'h44) begin fails++; $display("FAIL d1_head_old: got %h want 44", dn_payload[0]); end
        advance();
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        tests++; if (dn_payload[0] !== 8'h55) begin fails++; $display("FAIL d1_head_new: got %h want 55", dn_payload[0]); end
        tests++; if (occ[0] !== 1) begin fails++; $display("FAIL d1_occ: got %0d want 1", occ[0]); end
        tests++; if (up_ready[0] !== 1'b0) begin fails++; $display("FAIL d1_full_ready: got %b want 0", up_ready[0]); end
        #2 rst = 1'b1;
        #1;
        tests++; if (dn_valid[0] !== 1'b0) begin fails++; $display("FAIL d1_async_rst_valid: got %b want 0", dn_valid[0]); end
        tests++; if (dn_payload[0] !== NOP) begin fails++; $display("FAIL d1_async_rst_nop: got %h want %h", dn_payload[0], NOP); end
        tests++; if (occ[0] !== 0) begin fails++; $display("FAIL d1_async_rst_occ: got %0d want 0", occ[0]); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) mn[k] = 0;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_pl;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                up_valid[k]   = ($urandom_range(0, 2) != 0);
                up_payload[k] = DW'($urandom);
                dn_ready[k]   = ($urandom_range(0, 2) != 0);
                flush[k]      = ($urandom_range(0, 19) == 0);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                exp_pl = (mn[k] != 0) ? mq[k][0] : NOP;
                tests++; if (dn_valid[k] !== (mn[k] != 0)) begin fails++; $display("FAIL rand_valid[%0d] c=%0d: got %b want %b", k, c, dn_valid[k], mn[k] != 0); end
                tests++; if (dn_payload[k] !== exp_pl) begin fails++; $display("FAIL rand_payload[%0d] c=%0d: got %h want %h", k, c, dn_payload[k], exp_pl); end
                tests++; if (occ[k] !== mn[k]) begin fails++; $display("FAIL rand_occ[%0d] c=%0d: got %0d want %0d", k, c, occ[k], mn[k]); end
                tests++; if (up_ready[k] !== m_ready(k)) begin fails++; $display("FAIL rand_ready[%0d] c=%0d: got %b want %b", k, c, up_ready[k], m_ready(k)); end
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        repeat (2) @(negedge clk);
        test_reset();
        test_fill_hold();
        test_back_to_back();
        test_wrap();
        test_flush();
        test_depth1_replace();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
